// File: rtl/dp_executor_if.sv
// dp_executor_if
// Bundles the sequencer-side handshake, the RAM port and the VGA pixel port
// of the instruction executor.
//   master : instruction source / RAM model side (drives start, instruction,
//            mem_rdata; observes everything else)
//   slave  : the executor itself
// Signals:
//   start, instruction         request strobe and instruction word
//   finished, result           idle/done flag and result of last instruction
//   mem_addr/wdata/we, rdata   RAM port (read data valid 2 cycles after address)
//   vga_x/y/colour, vga_plot   single-pixel plot port
//   instr_count                completed-instruction counter
interface dp_executor_if #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 16,
    parameter int X_W     = 8,
    parameter int Y_W     = 7,
    parameter int COL_W   = 3,
    parameter int INSTR_W = 48
) ();
    logic                 start;
    logic [INSTR_W-1:0]   instruction;
    logic                 finished;
    logic [DATA_W-1:0]    result;
    logic [ADDR_W-1:0]    mem_addr;
    logic [DATA_W-1:0]    mem_wdata;
    logic                 mem_we;
    logic [DATA_W-1:0]    mem_rdata;
    logic [X_W-1:0]       vga_x;
    logic [Y_W-1:0]       vga_y;
    logic [COL_W-1:0]     vga_colour;
    logic                 vga_plot;
    logic [15:0]          instr_count;

    modport master (
        output start, instruction, mem_rdata,
        input  finished, result, mem_addr, mem_wdata, mem_we,
               vga_x, vga_y, vga_colour, vga_plot, instr_count
    );

    modport slave (
        input  start, instruction, mem_rdata,
        output finished, result, mem_addr, mem_wdata, mem_we,
               vga_x, vga_y, vga_colour, vga_plot, instr_count
    );
endinterface

// File: rtl/dp_executor.sv
// dp_executor
// Executes one instruction per start request: synchronous RAM read (two-cycle
// read latency), RAM write, or single-pixel VGA plot. Returns a result and
// raises finished when done.
// Ports:
//   clock   system clock, rising edge
//   resetn  synchronous, active-low reset
//   bus     dp_executor_if.slave (handshake, RAM port, VGA port, counter)
// Opcodes (instruction[3:0]): 0 NOP, 1 MEMREAD, 2 MEMWRITE, 3 DRAW,
// 4..15 behave as NOP.
module dp_executor #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 16,
    parameter int X_W     = 8,
    parameter int Y_W     = 7,
    parameter int COL_W   = 3,
    parameter int INSTR_W = 48
) (
    input  logic          clock,
    input  logic          resetn,
    dp_executor_if.slave  bus
);
    localparam logic [3:0] OP_MEMREAD  = 4'd1;
    localparam logic [3:0] OP_MEMWRITE = 4'd2;
    localparam logic [3:0] OP_DRAW     = 4'd3;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD1  = 3'd1;
    localparam logic [2:0] ST_RD2  = 3'd2;
    localparam logic [2:0] ST_RD3  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam int DATA_LSB  = 4 + ADDR_W;
    localparam int Y_LSB     = 4 + X_W;
    localparam int COL_LSB   = 4 + X_W + Y_W;
    localparam int PLOT_BIT  = 4 + X_W + Y_W + COL_W;
    localparam int MW_TOP    = 4 + ADDR_W + DATA_W;
    localparam int USED_BITS = (MW_TOP > PLOT_BIT + 1) ? MW_TOP : PLOT_BIT + 1;

    logic [2:0]          state_reg;
    logic                armed_reg;
    logic [3:0]          op_reg;
    logic [DATA_W-1:0]   data_reg;
    logic                finished_reg;
    logic [DATA_W-1:0]   result_reg;
    logic [ADDR_W-1:0]   mem_addr_reg;
    logic [DATA_W-1:0]   mem_wdata_reg;
    logic                mem_we_reg;
    logic [X_W-1:0]      vga_x_reg;
    logic [Y_W-1:0]      vga_y_reg;
    logic [COL_W-1:0]    vga_colour_reg;
    logic                vga_plot_reg;
    logic [15:0]         instr_count_reg;

    logic                accept;
    logic [3:0]          opcode;

    assign opcode = bus.instruction[3:0];
    // armed_reg only re-arms after start has been seen low, so a start held
    // high across several cycles runs exactly once.
    assign accept = bus.start && armed_reg && (state_reg == ST_IDLE);

    // Instruction bits above the widest field layout carry no meaning.
    generate
        if (USED_BITS < INSTR_W) begin : g_spare
            logic unused_instr_bits;
            assign unused_instr_bits = ^bus.instruction[INSTR_W-1:USED_BITS];
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_reg       <= ST_IDLE;
            armed_reg       <= 1'b1;
            op_reg          <= 4'd0;
            data_reg        <= '0;
            finished_reg    <= 1'b1;
            result_reg      <= '0;
            mem_addr_reg    <= '0;
            mem_wdata_reg   <= '0;
            mem_we_reg      <= 1'b0;
            vga_x_reg       <= '0;
            vga_y_reg       <= '0;
            vga_colour_reg  <= '0;
            vga_plot_reg    <= 1'b0;
            instr_count_reg <= 16'd0;
        end else begin
            // Strobes are single-cycle; they default low every cycle.
            mem_we_reg   <= 1'b0;
            vga_plot_reg <= 1'b0;

            if (!bus.start) begin
                armed_reg <= 1'b1;
            end else if (accept) begin
                armed_reg <= 1'b0;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        op_reg       <= opcode;
                        data_reg     <= bus.instruction[DATA_LSB +: DATA_W];
                        finished_reg <= 1'b0;
                        mem_addr_reg <= bus.instruction[4 +: ADDR_W];
                        if (opcode == OP_MEMWRITE) begin
                            mem_wdata_reg <= bus.instruction[DATA_LSB +: DATA_W];
                            mem_we_reg    <= 1'b1;
                        end
                        if (opcode == OP_DRAW) begin
                            vga_x_reg      <= bus.instruction[4 +: X_W];
                            vga_y_reg      <= bus.instruction[Y_LSB +: Y_W];
                            vga_colour_reg <= bus.instruction[COL_LSB +: COL_W];
                            vga_plot_reg   <= bus.instruction[PLOT_BIT];
                        end
                        state_reg <= (opcode == OP_MEMREAD) ? ST_RD1 : ST_DONE;
                    end
                end
                // Two wait cycles cover the RAM read latency; data is
                // captured at the end of RD3.
                ST_RD1: state_reg <= ST_RD2;
                ST_RD2: state_reg <= ST_RD3;
                ST_RD3: begin
                    result_reg      <= bus.mem_rdata;
                    finished_reg    <= 1'b1;
                    instr_count_reg <= instr_count_reg + 16'd1;
                    state_reg       <= ST_IDLE;
                end
                ST_DONE: begin
                    result_reg      <= (op_reg == OP_MEMWRITE) ? data_reg : '0;
                    finished_reg    <= 1'b1;
                    instr_count_reg <= instr_count_reg + 16'd1;
                    state_reg       <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.finished    = finished_reg;
    assign bus.result      = result_reg;
    assign bus.mem_addr    = mem_addr_reg;
    assign bus.mem_wdata   = mem_wdata_reg;
    assign bus.mem_we      = mem_we_reg;
    assign bus.vga_x       = vga_x_reg;
    assign bus.vga_y       = vga_y_reg;
    assign bus.vga_colour  = vga_colour_reg;
    assign bus.vga_plot    = vga_plot_reg;
    assign bus.instr_count = instr_count_reg;
endmodule

// File: tb/tb_dp_executor.sv
// tb_dp_executor
// Drives directed and random instructions into dp_executor and checks each
// one against a transaction-level model (expected latency, result, strobes,
// counter) plus a RAM with two-cycle read latency.
module tb_dp_executor;
    logic clock;
    logic resetn;

    dp_executor_if bus ();

    dp_executor dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks;
    int failures;

    logic [15:0] ref_mem [1024];
    logic [15:0] model_count;
    logic [15:0] ram [1024];
    logic [15:0] rd_pipe;

    function automatic logic [15:0] ram_init(input int i);
        if (i == 'h05A) return 16'hBEEF;
        return 16'(i * 40503) ^ 16'h5A5A;
    endfunction

    // RAM: write on mem_we, read data appears two cycles after the address.
    always @(posedge clock) begin
        if (!resetn) begin
            for (int i = 0; i < 1024; i++) ram[i] <= ram_init(i);
        end else if (bus.mem_we) begin
            ram[bus.mem_addr] <= bus.mem_wdata;
        end
        rd_pipe       <= ram[bus.mem_addr];
        bus.mem_rdata <= rd_pipe;
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [47:0] mk_read(input logic [9:0] a);
        return {34'd0, a, 4'd1};
    endfunction
    function automatic logic [47:0] mk_write(input logic [9:0] a, input logic [15:0] d);
        return {18'd0, d, a, 4'd2};
    endfunction
    function automatic logic [47:0] mk_draw(input logic [7:0] x, input logic [6:0] y,
                                            input logic [2:0] c, input logic p);
        return {25'd0, p, c, y, x, 4'd3};
    endfunction

    // One transaction: start held for `hold` cycles from cycle N, optional
    // extra one-cycle start pulse at N+extra_k (0 = none).
    task automatic run_instr(input string tag, input logic [47:0] ins, input int hold, input int extra_k);
        logic [3:0]  op;
        logic [9:0]  addr;
        logic [15:0] data;
        logic [15:0] exp_res;
        int          lat;
        int          win;
        int          we_n;
        int          plot_n;
        int          rise_k;
        logic        exp_we;
        logic        exp_plot;
        op       = ins[3:0];
        addr     = ins[13:4];
        data     = ins[29:14];
        lat      = (op == 4'd1) ? 4 : 2;
        exp_res  = (op == 4'd1) ? ref_mem[addr] : (op == 4'd2) ? data : 16'd0;
        exp_we   = (op == 4'd2);
        exp_plot = (op == 4'd3) && ins[22];
        win      = hold;
        if (lat > win) win = lat;
        if (extra_k + 1 > win) win = extra_k + 1;
        win += 2;
        we_n   = 0;
        plot_n = 0;
        rise_k = -1;

        @(negedge clock);
        bus.start       = 1'b1;
        bus.instruction = ins;
        for (int k = 1; k <= win; k++) begin
            @(negedge clock);
            if (k == 1) begin
                check_value({tag, " addr"}, 32'(bus.mem_addr), 32'(addr));
                check_value({tag, " we"}, 32'(bus.mem_we), 32'(exp_we));
                check_value({tag, " plot"}, 32'(bus.vga_plot), 32'(exp_plot));
                if (op == 4'd2)
                    check_value({tag, " wdata"}, 32'(bus.mem_wdata), 32'(data));
                if (op == 4'd3)
                    check_value({tag, " xyc"}, {14'd0, bus.vga_colour, bus.vga_y, bus.vga_x},
                                {14'd0, ins[21:4]});
            end
            we_n   += int'(bus.mem_we);
            plot_n += int'(bus.vga_plot);
            if (rise_k < 0 && bus.finished) begin
                rise_k = k;
                check_value({tag, " result"}, 32'(bus.result), 32'(exp_res));
            end
            if (k == hold) bus.start = 1'b0;
            if (extra_k > 0 && k == extra_k) bus.start = 1'b1;
            if (extra_k > 0 && k == extra_k + 1) bus.start = 1'b0;
        end
        if (op == 4'd2) ref_mem[addr] = data;
        model_count = model_count + 16'd1;
        check_value({tag, " latency"}, 32'(rise_k), 32'(lat));
        check_value({tag, " we_pulses"}, 32'(we_n), 32'(exp_we));
        check_value({tag, " plot_pulses"}, 32'(plot_n), 32'(exp_plot));
        check_value({tag, " count"}, 32'(bus.instr_count), 32'(model_count));
        check_value({tag, " result_hold"}, 32'(bus.result), 32'(exp_res));
        $display("txn %s op=%0d ins=%h result=%h count=%0d", tag, op, ins, bus.result, bus.instr_count);
    endtask

    initial begin
        logic [47:0] ins;
        int          r;
        checks      = 0;
        failures    = 0;
        model_count = 16'd0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = ram_init(i);

        resetn          = 1'b0;
        bus.start       = 1'b0;
        bus.instruction = '0;
        repeat (2) @(negedge clock);
        check_value("rst finished", 32'(bus.finished), 32'd1);
        check_value("rst result", 32'(bus.result), 32'd0);
        check_value("rst we", 32'(bus.mem_we), 32'd0);
        check_value("rst plot", 32'(bus.vga_plot), 32'd0);
        check_value("rst count", 32'(bus.instr_count), 32'd0);
        check_value("rst addr", 32'(bus.mem_addr), 32'd0);
        resetn = 1'b1;
        @(negedge clock);

        run_instr("read_05a", mk_read(10'h05A), 2, 0);
        run_instr("write_3ff", mk_write(10'h3FF, 16'h1234), 2, 0);
        run_instr("read_3ff", mk_read(10'h3FF), 1, 0);
        run_instr("draw_plot", mk_draw(8'd159, 7'd119, 3'b010, 1'b1), 2, 0);
        run_instr("draw_noplot", mk_draw(8'd159, 7'd119, 3'b010, 1'b0), 2, 0);
        run_instr("held20", mk_write(10'h011, 16'hA5A5), 20, 0);
        run_instr("read_midpulse", mk_read(10'h011), 2, 3);
        run_instr("illegal7", {44'hABCDE12345, 4'd7}, 2, 0);

        // Random mix, biased towards the legal opcodes.
        for (int t = 0; t < 40; t++) begin
            r   = $urandom_range(0, 7);
            ins = {$urandom, $urandom};
            ins[3:0] = (r < 4) ? 4'(r) : 4'($urandom_range(4, 15));
            run_instr($sformatf("rand%0d", t), ins, $urandom_range(1, 3), 0);
        end

        // Reset during the third cycle of a read: nothing completes.
        @(negedge clock);
        bus.start       = 1'b1;
        bus.instruction = mk_read(10'h05A);
        @(negedge clock);
        @(negedge clock);
        bus.start = 1'b0;
        resetn    = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        model_count = 16'd0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = ram_init(i);
        check_value("midrst finished", 32'(bus.finished), 32'd1);
        check_value("midrst result", 32'(bus.result), 32'd0);
        check_value("midrst count", 32'(bus.instr_count), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check_value("midrst idle_we", 32'(bus.mem_we), 32'd0);
            check_value("midrst idle_result", 32'(bus.result), 32'd0);
            check_value("midrst idle_finished", 32'(bus.finished), 32'd1);
        end
        check_value("midrst count_after", 32'(bus.instr_count), 32'd0);
        $display("txn midread_reset finished=%0d result=%h", bus.finished, bus.result);
        run_instr("post_reset_read", mk_read(10'h05A), 2, 0);

        // Counter wrap: jump the counter to its last value, then one NOP.
        @(negedge clock);
        force dut.instr_count_reg = 16'hFFFF;
        @(negedge clock);
        release dut.instr_count_reg;
        model_count = 16'hFFFF;
        run_instr("wrap_nop", 48'd0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
